gpio_event_capture: RTL and testbench
=====================================

GPIO_EVENT_CAPTURE -- requirements
Module: gpio_event_capture

Interface
REQ-001 Parameter GPIO_REG_WIDTH, default 12, number of GPIO input bits handled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive differing samples required to accept a new level; legal range 1..255.
REQ-003 Parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, 2..64.
REQ-004 Parameter TS_WIDTH, default 20, timestamp field width.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; asserted when low.
REQ-007 gpio_in  input  GPIO_REG_WIDTH  synchronized GPIO levels from the front-panel GPIO control stage.
REQ-008 rise_en  input  GPIO_REG_WIDTH  per-pin rising-edge event enable.
REQ-009 fall_en  input  GPIO_REG_WIDTH  per-pin falling-edge event enable.
REQ-010 clr_overflow  input  1  single-cycle pulse clearing overflow.
REQ-011 gpio_db  output  GPIO_REG_WIDTH  debounced levels.
REQ-012 evt_tdata  output  TS_WIDTH+2*GPIO_REG_WIDTH  {timestamp, rise_mask, fall_mask}, timestamp in MSBs.
REQ-013 evt_tvalid  output  1  FIFO head valid.
REQ-014 evt_tready  input  1  consumer accepts head.
REQ-015 evt_count  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-016 overflow  output  1  sticky: an event was dropped.

Function
REQ-017 Per pin: counter increments each cycle gpio_in[i] != gpio_db[i]; clears to 0 whenever gpio_in[i] == gpio_db[i].
REQ-018 On the edge where gpio_in[i] != gpio_db[i] is sampled for the DEBOUNCE_CYCLES-th consecutive time, gpio_db[i] takes gpio_in[i] and the counter clears.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES samples leaves gpio_db unchanged and generates no event.
REQ-020 On that same edge: rise_mask[i] = new level 1 and rise_en[i]; fall_mask[i] = new level 0 and fall_en[i]; enables sampled that cycle.
REQ-021 Masks for all pins updating on one edge merge into one event; an event is pushed only if rise_mask|fall_mask is nonzero; masked transitions still update gpio_db.
REQ-022 Free-running timestamp counter, TS_WIDTH bits, +1 every cycle, wraps from all-ones to 0; event carries its value on the gpio_db update edge.
REQ-023 Event written to FIFO one edge after the gpio_db update; evt_tvalid high after that edge when FIFO was empty (total DEBOUNCE_CYCLES+1 edges from first changed sample).
REQ-024 FIFO order first-in first-out; evt_tdata reflects head whenever evt_tvalid high and stays stable until popped.
REQ-025 Pop occurs only on an edge with evt_tvalid and evt_tready both high; evt_tready while empty has no effect.
REQ-026 Push while full without simultaneous pop: event dropped, overflow set next edge, FIFO contents unchanged.
REQ-027 Push while full with simultaneous pop: both performed, no drop, evt_count unchanged.
REQ-028 Push to empty FIFO is not visible on evt_tdata in the same cycle (no fall-through).
REQ-029 clr_overflow clears overflow next edge; coincident drop has priority (overflow stays 1).
REQ-030 evt_count equals pushes minus pops, always 0..FIFO_DEPTH.

Reset
REQ-031 While reset low: gpio_db, debounce counters, timestamp, FIFO pointers, evt_count, overflow all 0; evt_tvalid 0.
REQ-032 Reset mid-operation discards queued and pending events; after release gpio_db starts from 0, so pins high at release produce rising events after DEBOUNCE_CYCLES samples if enabled.

Configuration
REQ-033 Macro GPIO_EVT_TIMESTAMP_EN defined: timestamp counter present, per REQ-022.
REQ-034 Macro GPIO_EVT_TIMESTAMP_EN undefined: no counter; timestamp field of evt_tdata constant 0; evt_tdata width and all other behaviour unchanged.

Verification
REQ-035 Defaults, reset released, all enables 1; gpio_in 0x000->0x001 held -> gpio_db=0x001 after 4 edges; evt_tvalid next edge; rise_mask=0x001, fall_mask=0x000.
REQ-036 gpio_in bit3 high for 3 cycles then low -> gpio_db stays 0x000, evt_count stays 0.
REQ-037 gpio_in 0x000->0x0C0 with rise_en=0x040 -> gpio_db=0x0C0, one event rise_mask=0x040; then 0x0C0->0x000 with fall_en=0 -> no event.
REQ-038 evt_tready=0, 9 separated toggles of bit0 -> evt_count=8, overflow=1, first 8 events retained in order; clr_overflow pulse -> overflow=0.
REQ-039 FIFO full, evt_tready=1 on same edge as new event push -> evt_count stays 8, overflow stays 0, new event last in order.
REQ-040 With GPIO_EVT_TIMESTAMP_EN: two events 100 cycles apart -> timestamp difference 100; without macro -> timestamp field 0.

Source files
------------

// File: rtl/gpio_event_capture.sv
// gpio_event_capture: per-pin debounce, rise/fall event detection and an event FIFO.
// Each event carries {timestamp, rise_mask, fall_mask}.
// Optional macro GPIO_EVT_TIMESTAMP_EN adds a free-running timestamp counter.
// Without it, the timestamp field of evt_tdata is tied to zero.
module gpio_event_capture #(
  parameter int unsigned GPIO_REG_WIDTH  = 12,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned TS_WIDTH        = 20
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [GPIO_REG_WIDTH-1:0]            gpio_in,
  input  logic [GPIO_REG_WIDTH-1:0]            rise_en,
  input  logic [GPIO_REG_WIDTH-1:0]            fall_en,
  input  logic                                 clr_overflow,
  output logic [GPIO_REG_WIDTH-1:0]            gpio_db,
  output logic [TS_WIDTH+2*GPIO_REG_WIDTH-1:0] evt_tdata,
  output logic                                 evt_tvalid,
  input  logic                                 evt_tready,
  output logic [$clog2(FIFO_DEPTH):0]          evt_count,
  output logic                                 overflow
);

  localparam int unsigned GW     = GPIO_REG_WIDTH;
  localparam int unsigned DATA_W = TS_WIDTH + 2 * GPIO_REG_WIDTH;
  localparam int unsigned DB_W   = 8;
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = ADDR_W + 1;

  logic [GW-1:0]       r_db;
  logic [DB_W-1:0]     r_cnt [GW];
  logic [GW-1:0]       w_diff;
  logic [GW-1:0]       w_upd;
  logic [GW-1:0]       w_rise;
  logic [GW-1:0]       w_fall;
  logic [TS_WIDTH-1:0] w_ts;

  logic                r_stg_valid;
  logic [DATA_W-1:0]   r_stg_data;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]    r_count;
  logic [OCC_W-1:0]    w_count_nxt;
  logic                r_tvalid;
  logic                r_overflow;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

`ifdef GPIO_EVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;

  // Free-running timestamp, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= TS_WIDTH'(r_ts + 1'b1);
    end
  end

  assign w_ts = r_ts;
`else
  assign w_ts = '0;
`endif

  // Debounce accept strobes and event masks for this edge.
  always_comb begin
    w_diff = gpio_in ^ r_db;
    w_upd  = '0;
    for (int i = 0; i < int'(GW); i++) begin
      w_upd[i] = w_diff[i] && (r_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
    end
    w_rise = w_upd & gpio_in & rise_en;
    w_fall = w_upd & ~gpio_in & fall_en;
  end

  // Per-pin debounce counters and debounced levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db <= '0;
      for (int i = 0; i < int'(GW); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(GW); i++) begin
        if (w_upd[i]) begin
          r_db[i]  <= gpio_in[i];
          r_cnt[i] <= '0;
        end else if (w_diff[i]) begin
          r_cnt[i] <= DB_W'(r_cnt[i] + 1'b1);
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Event staging: captured on the gpio_db update edge, pushed on the next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
    end else begin
      r_stg_valid <= |(w_rise | w_fall);
      r_stg_data  <= {w_ts, w_rise, w_fall};
    end
  end

  // FIFO push/pop/drop decisions and next occupancy.
  always_comb begin
    w_full      = (r_count == OCC_W'(FIFO_DEPTH));
    w_pop       = r_tvalid && evt_tready;
    w_push      = r_stg_valid && (!w_full || w_pop);
    w_drop      = r_stg_valid && w_full && !w_pop;
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = OCC_W'(r_count + 1'b1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = OCC_W'(r_count - 1'b1);
    end
  end

  // FIFO pointers, occupancy, valid and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tvalid   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ADDR_W'(r_wr_ptr + 1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= ADDR_W'(r_rd_ptr + 1'b1);
      end
      r_count  <= w_count_nxt;
      r_tvalid <= (w_count_nxt != '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since valid is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_stg_data;
    end
  end

  assign gpio_db    = r_db;
  assign evt_tdata  = r_mem[r_rd_ptr];
  assign evt_tvalid = r_tvalid;
  assign evt_count  = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_gpio_event_capture.sv
// Testbench for gpio_event_capture: scoreboard of expected event masks checked on pop.
module tb_gpio_event_capture;

  localparam int unsigned GW = 12;
  localparam int unsigned DC = 4;
  localparam int unsigned FD = 8;
  localparam int unsigned TW = 20;
  localparam int unsigned DW = TW + 2 * GW;
  localparam int unsigned CW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [GW-1:0] gpio_in = '0;
  logic [GW-1:0] rise_en = '1;
  logic [GW-1:0] fall_en = '1;
  logic          clr_overflow = 1'b0;
  logic [GW-1:0] gpio_db;
  logic [DW-1:0] evt_tdata;
  logic          evt_tvalid;
  logic          evt_tready = 1'b0;
  logic [CW-1:0] evt_count;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  logic [2*GW-1:0] sb_q [$];
  logic [TW-1:0]   ts_log [$];

  gpio_event_capture #(
    .GPIO_REG_WIDTH (GW),
    .DEBOUNCE_CYCLES(DC),
    .FIFO_DEPTH     (FD),
    .TS_WIDTH       (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gpio_in     (gpio_in),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .clr_overflow(clr_overflow),
    .gpio_db     (gpio_db),
    .evt_tdata   (evt_tdata),
    .evt_tvalid  (evt_tvalid),
    .evt_tready  (evt_tready),
    .evt_count   (evt_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: a pop happens on the next rising edge when valid&ready here.
  always @(negedge clk) begin
    if (reset && evt_tvalid && evt_tready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got %h, expected no event", evt_tdata);
      end else begin
        logic [2*GW-1:0] exp_m;
        exp_m = sb_q.pop_front();
        if (evt_tdata[2*GW-1:0] !== exp_m) begin
          errors++;
          $display("FAIL evt_masks: got rise=%h fall=%h, expected rise=%h fall=%h",
                   evt_tdata[2*GW-1:GW], evt_tdata[GW-1:0], exp_m[2*GW-1:GW], exp_m[GW-1:0]);
        end
      end
      ts_log.push_back(evt_tdata[DW-1:2*GW]);
`ifndef GPIO_EVT_TIMESTAMP_EN
      checks++;
      if (evt_tdata[DW-1:2*GW] !== '0) begin
        errors++;
        $display("FAIL evt_ts_zero: got %h, expected 0", evt_tdata[DW-1:2*GW]);
      end
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input logic [GW-1:0] r, input logic [GW-1:0] f);
    sb_q.push_back({r, f});
  endtask

  // Pop everything; the consumer process does the per-event comparisons.
  task automatic drain();
    int budget;
    budget = 64;
    evt_tready = 1'b1;
    while ((sb_q.size() != 0 || evt_tvalid) && budget > 0) begin
      tick(1);
      budget--;
    end
    evt_tready = 1'b0;
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d events still expected, valid=%b", sb_q.size(), evt_tvalid);
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    checks++; if (gpio_db !== '0)   begin errors++; $display("FAIL rst_db: got %h, expected 0", gpio_db); end
    checks++; if (evt_tvalid !== 0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", evt_tvalid); end
    checks++; if (evt_count !== '0) begin errors++; $display("FAIL rst_count: got %0d, expected 0", evt_count); end
    checks++; if (overflow !== 0)   begin errors++; $display("FAIL rst_ovf: got %b, expected 0", overflow); end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_single_rise();
    gpio_in = 12'h001;
    expect_evt(12'h001, 12'h000);
    tick(DC - 1);
    checks++; if (gpio_db !== 12'h000) begin errors++; $display("FAIL rise_db_early: got %h, expected 000", gpio_db); end
    tick(1);
    checks++; if (gpio_db !== 12'h001) begin errors++; $display("FAIL rise_db: got %h, expected 001", gpio_db); end
    checks++; if (evt_tvalid !== 0)    begin errors++; $display("FAIL rise_valid_early: got %b, expected 0", evt_tvalid); end
    tick(1);
    checks++; if (evt_tvalid !== 1)    begin errors++; $display("FAIL rise_valid: got %b, expected 1", evt_tvalid); end
    checks++; if (evt_count !== CW'(1)) begin errors++; $display("FAIL rise_count: got %0d, expected 1", evt_count); end
    drain();
    gpio_in = 12'h000;
    expect_evt(12'h000, 12'h001);
    tick(DC + 2);
    drain();
    checks++; if (gpio_db !== 12'h000) begin errors++; $display("FAIL fall_db: got %h, expected 000", gpio_db); end
  endtask

  task automatic test_glitch();
    gpio_in = 12'h008;
    tick(DC - 1);
    gpio_in = 12'h000;
    tick(DC + 2);
    checks++; if (gpio_db !== 12'h000) begin errors++; $display("FAIL glitch_db: got %h, expected 000", gpio_db); end
    checks++; if (evt_count !== '0)    begin errors++; $display("FAIL glitch_count: got %0d, expected 0", evt_count); end
  endtask

  task automatic test_masked();
    rise_en = 12'h040;
    gpio_in = 12'h0C0;
    expect_evt(12'h040, 12'h000);
    tick(DC + 2);
    checks++; if (gpio_db !== 12'h0C0)  begin errors++; $display("FAIL mask_db: got %h, expected 0C0", gpio_db); end
    checks++; if (evt_count !== CW'(1)) begin errors++; $display("FAIL mask_count: got %0d, expected 1", evt_count); end
    drain();
    fall_en = '0;
    gpio_in = 12'h000;
    tick(DC + 2);
    checks++; if (gpio_db !== 12'h000) begin errors++; $display("FAIL mask_fall_db: got %h, expected 000", gpio_db); end
    checks++; if (evt_count !== '0)    begin errors++; $display("FAIL mask_fall_count: got %0d, expected 0", evt_count); end
    rise_en = '1;
    fall_en = '1;
  endtask

  task automatic test_overflow();
    evt_tready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      gpio_in = gpio_in ^ 12'h001;
      if (k <= 8) expect_evt({11'b0, gpio_in[0]}, {11'b0, ~gpio_in[0]});
      tick(DC + 2);
    end
    checks++; if (evt_count !== CW'(8)) begin errors++; $display("FAIL ovf_count: got %0d, expected 8", evt_count); end
    checks++; if (overflow !== 1)       begin errors++; $display("FAIL ovf_set: got %b, expected 1", overflow); end
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    checks++; if (overflow !== 0)       begin errors++; $display("FAIL ovf_clr: got %b, expected 0", overflow); end
    checks++; if (evt_count !== CW'(8)) begin errors++; $display("FAIL ovf_count_kept: got %0d, expected 8", evt_count); end
    drain();
  endtask

  task automatic test_back_to_back();
    evt_tready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      gpio_in = gpio_in ^ 12'h001;
      expect_evt({11'b0, gpio_in[0]}, {11'b0, ~gpio_in[0]});
      tick(DC + 2);
    end
    checks++; if (evt_count !== CW'(8)) begin errors++; $display("FAIL b2b_full: got %0d, expected 8", evt_count); end
    gpio_in = gpio_in ^ 12'h001;
    expect_evt({11'b0, gpio_in[0]}, {11'b0, ~gpio_in[0]});
    tick(DC);
    evt_tready = 1'b1;
    tick(1);
    evt_tready = 1'b0;
    checks++; if (evt_count !== CW'(8)) begin errors++; $display("FAIL b2b_count: got %0d, expected 8", evt_count); end
    tick(1);
    checks++; if (overflow !== 0)       begin errors++; $display("FAIL b2b_ovf: got %b, expected 0", overflow); end
    drain();
  endtask

  task automatic test_timestamp();
    ts_log.delete();
    gpio_in = 12'h001;
    expect_evt(12'h001, 12'h000);
    tick(100);
    gpio_in = 12'h000;
    expect_evt(12'h000, 12'h001);
    tick(DC + 2);
    drain();
    checks++;
    if (ts_log.size() != 2) begin
      errors++;
      $display("FAIL ts_events: got %0d events, expected 2", ts_log.size());
    end else begin
`ifdef GPIO_EVT_TIMESTAMP_EN
      checks++;
      if (TW'(ts_log[1] - ts_log[0]) !== TW'(100)) begin
        errors++;
        $display("FAIL ts_delta: got %0d, expected 100", TW'(ts_log[1] - ts_log[0]));
      end
`else
      checks++;
      if ((ts_log[0] | ts_log[1]) !== '0) begin
        errors++;
        $display("FAIL ts_off: got %h/%h, expected 0/0", ts_log[0], ts_log[1]);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    evt_tready = 1'b0;
    gpio_in = 12'h005;
    tick(DC + 2);
    checks++; if (evt_count !== CW'(1)) begin errors++; $display("FAIL mid_pre_count: got %0d, expected 1", evt_count); end
    reset = 1'b0;
    tick(1);
    checks++; if (evt_count !== '0)    begin errors++; $display("FAIL mid_rst_count: got %0d, expected 0", evt_count); end
    checks++; if (evt_tvalid !== 0)    begin errors++; $display("FAIL mid_rst_valid: got %b, expected 0", evt_tvalid); end
    checks++; if (gpio_db !== 12'h000) begin errors++; $display("FAIL mid_rst_db: got %h, expected 000", gpio_db); end
    reset = 1'b1;
    expect_evt(12'h005, 12'h000);
    tick(DC);
    checks++; if (gpio_db !== 12'h005) begin errors++; $display("FAIL mid_rel_db: got %h, expected 005", gpio_db); end
    tick(1);
    checks++; if (evt_tvalid !== 1)    begin errors++; $display("FAIL mid_rel_valid: got %b, expected 1", evt_tvalid); end
    drain();
    gpio_in = 12'h000;
    expect_evt(12'h000, 12'h005);
    tick(DC + 2);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_masked();
    test_overflow();
    test_back_to_back();
    test_timestamp();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
